// File: rtl/intersection_scheduler.sv
// Two-approach (NS/EW) phase scheduler: left/green/yellow/all-red sequencing,
// rest-on-green, latched left-turn demand and emergency preemption.
// Lamps decode the state register only, so the two approaches never conflict.
module intersection_scheduler #(
  parameter int LEFT_CYC   = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  input  logic       emg_dir,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       req_left_ns,
  input  logic       req_left_ew,
  output logic       LeftTurn_NS,
  output logic       Green_NS,
  output logic       Yellow_NS,
  output logic       Red_NS,
  output logic       LeftTurn_EW,
  output logic       Green_EW,
  output logic       Yellow_EW,
  output logic       Red_EW,
  output logic [3:0] phase
);

  localparam int MAX_A = (LEFT_CYC > GREEN_CYC) ? LEFT_CYC : GREEN_CYC;
  localparam int MAX_B = (YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [3:0] {
    RST_RED    = 4'd0,
    NS_LEFT    = 4'd1,
    NS_GREEN   = 4'd2,
    NS_YELLOW  = 4'd3,
    NS_CLEAR   = 4'd4,
    EW_LEFT    = 4'd5,
    EW_GREEN   = 4'd6,
    EW_YELLOW  = 4'd7,
    EW_CLEAR   = 4'd8,
    EMG_YELLOW = 4'd9,
    EMG_CLEAR  = 4'd10,
    EMG_GREEN  = 4'd11
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic          lp_ns, lp_ew;     // latched left-turn demand
  logic          emg_q;            // captured preempting approach
  logic          emg_pend;         // preemption seen while finishing yellow/clear
  logic          emg_src;          // approach shown yellow in EMG_YELLOW
  logic          t0, in_emg, emg_take, emg_act, edir;

  assign t0       = (timer == '0);
  assign in_emg   = (state == EMG_YELLOW) || (state == EMG_CLEAR) || (state == EMG_GREEN);
  // emg_dir is only looked at on the first edge emergency is seen
  assign emg_take = emergency && !in_emg && !emg_pend;
  assign emg_act  = emg_take || emg_pend;
  assign edir     = emg_pend ? emg_q : emg_dir;
  assign phase    = state;

  // Timer reload value (duration minus one) for each state
  function automatic logic [TW-1:0] dur_m1(input state_t s);
    case (s)
      NS_LEFT, EW_LEFT:                 dur_m1 = TW'(LEFT_CYC - 1);
      NS_GREEN, EW_GREEN:               dur_m1 = TW'(GREEN_CYC - 1);
      NS_YELLOW, EW_YELLOW, EMG_YELLOW: dur_m1 = TW'(YELLOW_CYC - 1);
      EMG_GREEN:                        dur_m1 = '0;
      default:                          dur_m1 = TW'(ALLRED_CYC - 1);
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_RED;
    else      state <= state_n;
  end

  // Next-state: preemption from green/left acts at once, yellow/clear finish first
  always_comb begin
    state_n = state;
    case (state)
      RST_RED:    if (t0) state_n = emg_act ? EMG_GREEN : (lp_ns ? NS_LEFT : NS_GREEN);
      NS_LEFT:    if (emg_act) state_n = EMG_YELLOW;
                  else if (t0) state_n = NS_GREEN;
      NS_GREEN:   if (emg_act) state_n = edir ? EMG_YELLOW : EMG_GREEN;
                  else if (t0 && (req_ew || lp_ew)) state_n = NS_YELLOW;
      NS_YELLOW:  if (t0) state_n = emg_act ? EMG_CLEAR : NS_CLEAR;
      NS_CLEAR:   if (t0) state_n = emg_act ? EMG_GREEN : (lp_ew ? EW_LEFT : EW_GREEN);
      EW_LEFT:    if (emg_act) state_n = EMG_YELLOW;
                  else if (t0) state_n = EW_GREEN;
      EW_GREEN:   if (emg_act) state_n = edir ? EMG_GREEN : EMG_YELLOW;
                  else if (t0 && (req_ns || lp_ns)) state_n = EW_YELLOW;
      EW_YELLOW:  if (t0) state_n = emg_act ? EMG_CLEAR : EW_CLEAR;
      EW_CLEAR:   if (t0) state_n = emg_act ? EMG_GREEN : (lp_ns ? NS_LEFT : NS_GREEN);
      EMG_YELLOW: if (t0) state_n = EMG_CLEAR;
      EMG_CLEAR:  if (t0) state_n = EMG_GREEN;
      EMG_GREEN:  if (!emergency) state_n = emg_q ? EW_YELLOW : NS_YELLOW;
      default:    state_n = RST_RED;
    endcase
  end

  // Phase timer, left latches (set wins over clear) and preemption bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer    <= TW'(ALLRED_CYC - 1);
      lp_ns    <= 1'b0;
      lp_ew    <= 1'b0;
      emg_q    <= 1'b0;
      emg_pend <= 1'b0;
      emg_src  <= 1'b0;
    end else begin
      if (state_n != state || t0) timer <= dur_m1(state_n);
      else                        timer <= timer - TW'(1);
      lp_ns <= req_left_ns | (lp_ns & !(state_n == NS_LEFT && state != NS_LEFT));
      lp_ew <= req_left_ew | (lp_ew & !(state_n == EW_LEFT && state != EW_LEFT));
      if (emg_take) emg_q <= emg_dir;
      emg_pend <= (state_n == EMG_YELLOW || state_n == EMG_CLEAR || state_n == EMG_GREEN)
                  ? 1'b0 : (emg_pend | emg_take);
      if (state_n == EMG_YELLOW && state != EMG_YELLOW)
        emg_src <= (state == EW_LEFT) || (state == EW_GREEN);
    end
  end

  // Lamp decode; the non-served approach is always red
  always_comb begin
    {LeftTurn_NS, Green_NS, Yellow_NS, Red_NS} = 4'b0001;
    {LeftTurn_EW, Green_EW, Yellow_EW, Red_EW} = 4'b0001;
    case (state)
      NS_LEFT:    {LeftTurn_NS, Red_NS} = 2'b10;
      NS_GREEN:   {Green_NS, Red_NS}    = 2'b10;
      NS_YELLOW:  {Yellow_NS, Red_NS}   = 2'b10;
      EW_LEFT:    {LeftTurn_EW, Red_EW} = 2'b10;
      EW_GREEN:   {Green_EW, Red_EW}    = 2'b10;
      EW_YELLOW:  {Yellow_EW, Red_EW}   = 2'b10;
      EMG_YELLOW: if (emg_src) {Yellow_EW, Red_EW} = 2'b10;
                  else         {Yellow_NS, Red_NS} = 2'b10;
      EMG_GREEN:  if (emg_q)   {Green_EW, Red_EW}  = 2'b10;
                  else         {Green_NS, Red_NS}  = 2'b10;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed scenarios plus random demand,
// emergency and reset traffic, compared every cycle against a segment model.
module tb_intersection_scheduler;

  localparam int LC = 4, GC = 8, YC = 3, AC = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic emergency = 1'b0, emg_dir = 1'b0;
  logic req_ns = 1'b0, req_ew = 1'b0, req_left_ns = 1'b0, req_left_ew = 1'b0;
  logic LeftTurn_NS, Green_NS, Yellow_NS, Red_NS;
  logic LeftTurn_EW, Green_EW, Yellow_EW, Red_EW;
  logic [3:0] phase;
  logic [7:0] lamps;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign lamps = {LeftTurn_NS, Green_NS, Yellow_NS, Red_NS,
                  LeftTurn_EW, Green_EW, Yellow_EW, Red_EW};

  intersection_scheduler #(.LEFT_CYC(LC), .GREEN_CYC(GC), .YELLOW_CYC(YC), .ALLRED_CYC(AC)) dut (
    .clk(clk), .rst(rst), .emergency(emergency), .emg_dir(emg_dir),
    .req_ns(req_ns), .req_ew(req_ew), .req_left_ns(req_left_ns), .req_left_ew(req_left_ew),
    .LeftTurn_NS(LeftTurn_NS), .Green_NS(Green_NS), .Yellow_NS(Yellow_NS), .Red_NS(Red_NS),
    .LeftTurn_EW(LeftTurn_EW), .Green_EW(Green_EW), .Yellow_EW(Yellow_EW), .Red_EW(Red_EW),
    .phase(phase)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: current lamp segment, its approach and age ----
  typedef enum int {K_RED, K_LEFT, K_GRN, K_YEL, K_CLR, K_EYEL, K_ECLR, K_EGRN} kind_t;
  kind_t m_k;
  int    m_d, m_age;
  bit    m_edir, m_pend;
  bit    lp[2];

  function automatic int dur(input kind_t k);
    case (k)
      K_LEFT:        return LC;
      K_GRN:         return GC;
      K_YEL, K_EYEL: return YC;
      default:       return AC;
    endcase
  endfunction

  function automatic bit is_emg(input kind_t k);
    return (k == K_EYEL) || (k == K_ECLR) || (k == K_EGRN);
  endfunction

  task automatic m_reset();
    m_k = K_RED; m_d = 0; m_age = 1; m_edir = 0; m_pend = 0; lp[0] = 0; lp[1] = 0;
  endtask

  task automatic m_step();
    bit first, act, done, ed;
    bit req[2], rl[2];
    kind_t nk;
    int nd;
    req[0] = req_ns; req[1] = req_ew; rl[0] = req_left_ns; rl[1] = req_left_ew;
    first = emergency && !is_emg(m_k) && !m_pend;
    act   = first || m_pend;
    ed    = first ? emg_dir : m_edir;
    done  = (m_age >= dur(m_k));
    nk = m_k; nd = m_d;
    case (m_k)
      K_RED:  if (done) begin
                if (act) nk = K_EGRN;
                else begin nd = 0; nk = lp[0] ? K_LEFT : K_GRN; end
              end
      K_LEFT: if (act) nk = K_EYEL; else if (done) nk = K_GRN;
      K_GRN:  if (act) nk = (int'(ed) == m_d) ? K_EGRN : K_EYEL;
              else if (done && (req[1-m_d] || lp[1-m_d])) nk = K_YEL;
      K_YEL:  if (done) nk = act ? K_ECLR : K_CLR;
      K_CLR:  if (done) begin
                if (act) nk = K_EGRN;
                else begin nd = 1 - m_d; nk = lp[nd] ? K_LEFT : K_GRN; end
              end
      K_EYEL: if (done) nk = K_ECLR;
      K_ECLR: if (done) nk = K_EGRN;
      K_EGRN: if (!emergency) nk = K_YEL;
      default: nk = K_RED;
    endcase
    if (nk == K_EGRN && m_k != K_EGRN) nd = int'(ed);
    for (int x = 0; x < 2; x++)
      lp[x] = rl[x] | (lp[x] && !(nk == K_LEFT && nd == x && !(m_k == K_LEFT && m_d == x)));
    if (first) m_edir = emg_dir;
    m_pend = is_emg(nk) ? 1'b0 : (m_pend | first);
    if (nk != m_k || nd != m_d || (m_k == K_GRN && done)) m_age = 1;
    else m_age++;
    m_k = nk; m_d = nd;
  endtask

  function automatic logic [7:0] m_lamps();
    logic [3:0] a[2];
    a[0] = 4'b0001; a[1] = 4'b0001;
    case (m_k)
      K_LEFT:        a[m_d] = 4'b1000;
      K_GRN, K_EGRN: a[m_d] = 4'b0100;
      K_YEL, K_EYEL: a[m_d] = 4'b0010;
      default: ;
    endcase
    return {a[0], a[1]};
  endfunction

  // ---- cycle driver: model advances on the edge, DUT sampled on negedge ----
  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("lamps", 32'(lamps), 32'(m_lamps()));
    chk("onehot_ns", 32'($countones(lamps[7:4])), 32'd1);
    chk("onehot_ew", 32'($countones(lamps[3:0])), 32'd1);
    chk("no_conflict", 32'(Red_NS | Red_EW), 32'd1);
    chk("phase_range", 32'(phase < 4'd12), 32'd1);
  endtask

  task automatic wait_for(input string tag, input logic [7:0] pat, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (lamps == pat) break;
      cyc();
    end
    chk(tag, 32'(lamps), 32'(pat));
  endtask

  // Mid-cycle asynchronous reset pulse; lamps must go all-red without a clock
  task automatic do_areset();
    #2 rst = 1'b0;
    #1 chk("async_rst", 32'(lamps), 32'h11);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1 chk("rst_state", 32'(lamps), 32'h11);
    m_reset();
    @(negedge clk);
    rst = 1'b1;

    // all-red for ALLRED_CYC edges, then rest on NS green
    cyc(); chk("red_hold", 32'(lamps), 32'h11);
    cyc(); chk("first_green", 32'(lamps), 32'h41);
    repeat (20) cyc();
    chk("rest_green", 32'(lamps), 32'h41);

    // EW demand held: full NS->EW handover, EW rests with no NS demand
    req_ew = 1'b1;
    repeat (30) cyc();
    chk("ew_rest", 32'(lamps), 32'h14);

    // single-cycle EW left pulse while NS green
    req_ns = 1'b1; req_ew = 1'b0;
    wait_for("ns_green_a", 8'h41, 100);
    req_left_ew = 1'b1; cyc(); req_left_ew = 1'b0;
    wait_for("ew_left", 8'h18, 60);
    repeat (LC) cyc();
    chk("ew_after_left", 32'(lamps), 32'h14);
    repeat (40) cyc();

    // preempt toward EW from NS green
    req_ns = 1'b0;
    wait_for("ns_green_b", 8'h41, 100);
    emergency = 1'b1; emg_dir = 1'b1;
    cyc(); chk("emg_yellow", 32'(lamps), 32'h21);
    emg_dir = 1'b0;
    repeat (YC + AC + 20) cyc();
    chk("emg_hold", 32'(lamps), 32'h14);
    emergency = 1'b0;
    cyc(); chk("emg_exit", 32'(lamps), 32'h12);
    repeat (10) cyc();

    // preempt for the approach already green: no glitch
    wait_for("ns_green_c", 8'h41, 100);
    emergency = 1'b1; emg_dir = 1'b0;
    repeat (10) begin cyc(); chk("emg_ns_hold", 32'(lamps), 32'h41); end
    emergency = 1'b0;
    cyc(); chk("emg_ns_drop", 32'(lamps), 32'h21);

    // reset during EW yellow and during emergency green
    req_ns = 1'b1; req_ew = 1'b1;
    wait_for("ew_yellow", 8'h12, 100);
    do_areset();
    cyc(); chk("rst_red1", 32'(lamps), 32'h11);
    cyc(); chk("rst_green1", 32'(lamps), 32'h41);
    emergency = 1'b1; emg_dir = 1'b1;
    wait_for("emg_green", 8'h14, 100);
    do_areset();
    emergency = 1'b0;
    cyc(); chk("rst_red2", 32'(lamps), 32'h11);
    cyc(); chk("rst_green2", 32'(lamps), 32'h41);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      req_ns      = ($urandom_range(0, 3) != 0);
      req_ew      = ($urandom_range(0, 2) == 0);
      req_left_ns = ($urandom_range(0, 15) == 0);
      req_left_ew = ($urandom_range(0, 15) == 0);
      if (emergency) begin if ($urandom_range(0, 24) == 0) emergency = 1'b0; end
      else if ($urandom_range(0, 59) == 0) emergency = 1'b1;
      emg_dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) do_areset();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
